// File: rtl/btn_reset_pkg.sv
// btn_reset_pkg: shared reset-FSM state type and debounce length helper for btn_reset_ctrl.
package btn_reset_pkg;

    typedef enum logic [1:0] {POR, RUN, HOLD} rst_state_t;

    function automatic int db_cycles(input int freq_mhz, input int ms);
        return freq_mhz * 1000 * ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button's 2-flop synchronizer, debounce counter and edge pulses.
// Edge pulse registers exist only when BTN_EDGE_EN is defined.
module btn_debounce #(
    parameter int DB_CYCLES  = 250000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset_ni,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          pressed;
    logic          flip;

    // Flops come out of reset at the raw released level so no phantom press appears.
    always_ff @(posedge clk or negedge reset_ni)
        if (!reset_ni) sync <= {2{ACTIVE_LOW}};
        else           sync <= {sync[0], btn_i};

    assign pressed = sync[1] ^ ACTIVE_LOW;
    assign flip    = (pressed != btn_o) && (cnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_ni)
        if (!reset_ni) begin
            cnt   <= '0;
            btn_o <= 1'b0;
        end else begin
            cnt   <= (pressed == btn_o || flip) ? '0 : cnt + 1'b1;
            btn_o <= btn_o ^ flip;
        end

`ifdef BTN_EDGE_EN
    always_ff @(posedge clk or negedge reset_ni)
        if (!reset_ni) begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            press_o   <= flip & ~btn_o;
            release_o <= flip & btn_o;
        end
`else
    assign press_o   = 1'b0;
    assign release_o = 1'b0;
`endif

endmodule

// File: rtl/btn_reset_ctrl.sv
// btn_reset_ctrl: debounced buttons plus SoC reset from power-on stretch, reset button and reset_ni.
// Define BTN_EDGE_EN to build the press/release pulse outputs.
module btn_reset_ctrl
    import btn_reset_pkg::*;
#(
    parameter int              FREQ_MHZ        = 25,
    parameter int              DEBOUNCE_MS     = 10,
    parameter int              POR_CYCLES      = 32,
    parameter int              NBTN            = 7,
    parameter logic [NBTN-1:0] ACTIVE_LOW_MASK = 7'b0000001,
    parameter int              RESET_BTN       = 0
) (
    input  logic            clk,
    input  logic            reset_ni,
    input  logic [NBTN-1:0] btn_i,
    output logic [NBTN-1:0] btn_o,
    output logic [NBTN-1:0] btn_press_o,
    output logic [NBTN-1:0] btn_release_o,
    output logic            reset_o
);
    localparam int DB_CYCLES = db_cycles(FREQ_MHZ, DEBOUNCE_MS);
    localparam int PW        = $clog2(POR_CYCLES + 1);

    rst_state_t    state, state_d;
    logic [PW-1:0] por_cnt, por_cnt_d;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .ACTIVE_LOW(ACTIVE_LOW_MASK[i])
        ) u_db (
            .clk      (clk),
            .reset_ni (reset_ni),
            .btn_i    (btn_i[i]),
            .btn_o    (btn_o[i]),
            .press_o  (btn_press_o[i]),
            .release_o(btn_release_o[i])
        );
    end

    always_comb begin
        state_d   = state;
        por_cnt_d = '0;
        case (state)
            POR: begin
                por_cnt_d = por_cnt + 1'b1;
                if (por_cnt == PW'(POR_CYCLES - 1)) begin
                    state_d   = RUN;
                    por_cnt_d = '0;
                end
            end
            RUN:     if (btn_o[RESET_BTN])  state_d = HOLD;
            HOLD:    if (!btn_o[RESET_BTN]) state_d = POR;
            default: state_d = POR;
        endcase
    end

    // reset_o follows the next state so it drops on the same edge that enters RUN.
    always_ff @(posedge clk or negedge reset_ni)
        if (!reset_ni) begin
            state   <= POR;
            por_cnt <= '0;
            reset_o <= 1'b1;
        end else begin
            state   <= state_d;
            por_cnt <= por_cnt_d;
            reset_o <= (state_d != RUN);
        end

endmodule

// File: tb/tb_btn_reset_ctrl.sv
// tb_btn_reset_ctrl: randomized directed run of btn_reset_ctrl against a cycle-level behavioural model.
module tb_btn_reset_ctrl;
    localparam int         NB   = 7;
    localparam int         DB   = 1000;
    localparam int         POR  = 32;
    localparam logic [6:0] MASK = 7'b0000001;
`ifdef BTN_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_ni = 1'b0;
    logic [6:0] btn_i = MASK;
    logic [6:0] btn_o, btn_press_o, btn_release_o;
    logic       reset_o;

    always #5 clk = ~clk;

    btn_reset_ctrl #(
        .FREQ_MHZ(1), .DEBOUNCE_MS(1), .POR_CYCLES(POR), .NBTN(NB),
        .ACTIVE_LOW_MASK(MASK), .RESET_BTN(0)
    ) dut (
        .clk(clk), .reset_ni(reset_ni), .btn_i(btn_i), .btn_o(btn_o),
        .btn_press_o(btn_press_o), .btn_release_o(btn_release_o), .reset_o(reset_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state in the pressed=1 domain: two-cycle delay line, debounced level,
    // mismatch run lengths, and the reset sequencing as edges-left / holding flag.
    logic [6:0] h1, h2, deb, mp, mr;
    int         run_len [NB];
    int         pending;
    bit         holding;
    logic       mrst;

    task automatic model_reset();
        h1 = '0; h2 = '0; deb = '0; mp = '0; mr = '0;
        for (int i = 0; i < NB; i++) run_len[i] = 0;
        pending = POR; holding = 1'b0; mrst = 1'b1;
    endtask

    task automatic model_step();
        logic d0;
        d0 = deb[0];
        mp = '0; mr = '0;
        for (int i = 0; i < NB; i++) begin
            if (h2[i] != deb[i]) begin
                run_len[i]++;
                if (run_len[i] == DB) begin
                    deb[i] = ~deb[i];
                    run_len[i] = 0;
                    if (deb[i]) mp[i] = 1'b1; else mr[i] = 1'b1;
                end
            end else run_len[i] = 0;
        end
        h2 = h1;
        h1 = btn_i ^ MASK;
        if (holding) begin
            if (!d0) begin holding = 1'b0; pending = POR; end
        end else if (pending > 0) begin
            pending--;
            if (pending == 0) mrst = 1'b0;
        end else if (d0) begin
            holding = 1'b1; mrst = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("btn_o", btn_o, deb);
        chk("btn_press_o", btn_press_o, EDGE ? mp : 7'b0);
        chk("btn_release_o", btn_release_o, EDGE ? mr : 7'b0);
        chk("reset_o", {6'b0, reset_o}, {6'b0, mrst});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_ni) model_reset(); else model_step();
        #1 check_all();
    endtask

    task automatic hold(input logic [6:0] pressed, input int n);
        btn_i = pressed ^ MASK;
        repeat (n) tick();
    endtask

    task automatic async_abort();
        #2 reset_ni = 1'b0;
        #1 model_reset();
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (5) tick();
        reset_ni = 1'b1;
        hold(7'b0, 40);
        hold(7'b0001000, 999);
        hold(7'b0, 1100);
        hold(7'b0001000, 2000);
        hold(7'b0, 1100);
        hold(7'b0000001, 3000);
        hold(7'b0, 1100);
        repeat (8) begin
            hold(7'($urandom), $urandom_range(990, 1010));
            hold(7'b0, 1100);
        end
        hold(7'b1000000, 1100);
        hold(7'b1100000, 502);
        async_abort();
        repeat (3) tick();
        reset_ni = 1'b1;
        hold(7'b1100000, 10);
        async_abort();
        repeat (2) tick();
        reset_ni = 1'b1;
        hold(7'b1100000, 1100);
        hold(7'b0, 1100);
        repeat (20) hold(7'($urandom), $urandom_range(1, 1500));
        hold(7'b0, 1200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
